goertzel_bin: RTL and testbench

- Single-bin Goertzel filter core, one instance per analysed frequency.
- Sits downstream of the register block and the coefficient (CORDIC) stage. Consumes num_samp, mode, reset_h and a per-bin coefficient 2·cos(w).
- Produces the bin power word and the valid flag that the register block gathers into its data array (data is captured when all bin valids are high).

---
 rtl/goertzel_bin.sv | 209 ++++++++++++++++++++
 tb/tb_goertzel_bin.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_bin.sv
// Single-bin Goertzel filter: accumulates one block of samples, then derives bin power in three cycles.
// Define GOERTZEL_SAT_EN to saturate the state update and report clamps on ovf_o.
module goertzel_bin #(
    parameter int DW     = 16,
    parameter int CW     = 18,
    parameter int SW     = 32,
    parameter int PSHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 mode_i,
    input  logic                 clr_i,
    input  logic signed [CW-1:0] coef_i,
    input  logic                 coef_valid_i,
    input  logic [31:0]          num_samp_i,
    input  logic signed [DW-1:0] samp_i,
    input  logic                 samp_valid_i,
    output logic                 busy_o,
    output logic [31:0]          power_o,
    output logic                 valid_o,
    output logic                 ovf_o
);
    localparam int CF = CW - 2;

    typedef enum logic [2:0] {IDLE, ACCUM, FIN1, FIN2, FIN3} state_t;

    state_t                 state_q, state_d;
    logic signed [SW-1:0]   s1_q, s1_d, s2_q, s2_d;
    logic [31:0]            cnt_q, cnt_d, n_q, n_d;
    logic signed [CW-1:0]   coef_q, coef_d;
    logic                   mode_q, mode_d;
    logic signed [2*SW-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [31:0]            power_q, power_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    // Feedback term coef*s1 scaled back to integer; reused by the accumulate and the final cross term.
    logic signed [CW+SW-1:0]  prod_fb;
    logic signed [SW+1:0]     fb;
    logic signed [SW+1:0]     sum;
    logic                     sum_fits;
    logic signed [SW-1:0]     s_new;
    logic signed [SW-1:0]     sq_src;
    logic signed [2*SW-1:0]   sq;
    logic signed [2*SW+1:0]   p3;
    logic signed [2*SW+1:0]   r;
    logic signed [2*SW+1:0]   r_sh;
    logic [31:0]              pwr_clamped;
    logic                     start_ok;

    assign prod_fb  = coef_q * s1_q;
    assign fb       = prod_fb[CF+SW+1:CF];
    assign sum      = {{(SW+2-DW){samp_i[DW-1]}}, samp_i} + fb - {{2{s2_q[SW-1]}}, s2_q};
    assign sum_fits = (sum[SW+1:SW-1] == {3{sum[SW-1]}});

`ifdef GOERTZEL_SAT_EN
    logic ovf_q, ovf_d;
    logic unused_bits;
    assign unused_bits = ^prod_fb[CF-1:0];
    assign s_new = sum_fits ? sum[SW-1:0]
                 : (sum[SW+1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}});
    assign ovf_o = ovf_q;
`else
    logic unused_bits;
    assign unused_bits = ^{prod_fb[CF-1:0], sum[SW+1:SW], sum_fits};
    assign s_new = sum[SW-1:0];
    assign ovf_o = 1'b0;
`endif

    // One squarer serves both FIN1 (s1^2) and FIN2 (s2^2).
    assign sq_src = (state_q == FIN1) ? s1_q : s2_q;
    assign sq     = sq_src * sq_src;
    assign p3     = fb * s2_q;
    assign r      = {{2{p1_q[2*SW-1]}}, p1_q} + {{2{p2_q[2*SW-1]}}, p2_q} - p3;
    assign r_sh   = r >>> PSHIFT;

    always_comb begin
        pwr_clamped = r_sh[31:0];
        if (r_sh[2*SW+1]) begin
            pwr_clamped = 32'd0;
        end else if (|r_sh[2*SW:32]) begin
            pwr_clamped = 32'hFFFF_FFFF;
        end
    end

    assign start_ok = en_i & coef_valid_i & (num_samp_i != 32'd0) & (mode_i | ~valid_q);

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        coef_d  = coef_q;
        mode_d  = mode_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        power_d = power_q;
        valid_d = valid_q;
`ifdef GOERTZEL_SAT_EN
        ovf_d   = ovf_q;
`endif
        if (clr_i) begin
            state_d = IDLE;
            s1_d    = '0;
            s2_d    = '0;
            cnt_d   = '0;
            n_d     = '0;
            coef_d  = '0;
            mode_d  = 1'b0;
            p1_d    = '0;
            p2_d    = '0;
            power_d = '0;
            valid_d = 1'b0;
`ifdef GOERTZEL_SAT_EN
            ovf_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_d = ACCUM;
                        coef_d  = coef_i;
                        n_d     = num_samp_i;
                        mode_d  = mode_i;
                        s1_d    = '0;
                        s2_d    = '0;
                        cnt_d   = '0;
                    end
                end
                ACCUM: begin
                    if (samp_valid_i) begin
                        s2_d  = s1_q;
                        s1_d  = s_new;
                        cnt_d = cnt_q + 32'd1;
`ifdef GOERTZEL_SAT_EN
                        if (!sum_fits) ovf_d = 1'b1;
`endif
                        if (cnt_q == n_q - 32'd1) state_d = FIN1;
                    end
                end
                FIN1: begin
                    p1_d    = sq;
                    state_d = FIN2;
                end
                FIN2: begin
                    p2_d    = sq;
                    state_d = FIN3;
                end
                FIN3: begin
                    power_d = pwr_clamped;
                    valid_d = 1'b1;
                    if (mode_q & en_i) begin
                        state_d = ACCUM;
                        s1_d    = '0;
                        s2_d    = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            coef_q  <= '0;
            mode_q  <= 1'b0;
            p1_q    <= '0;
            p2_q    <= '0;
            power_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            coef_q  <= coef_d;
            mode_q  <= mode_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            power_q <= power_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

`ifdef GOERTZEL_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
`endif

    assign busy_o  = busy_q;
    assign power_o = power_q;
    assign valid_o = valid_q;
endmodule

// File: tb/tb_goertzel_bin.sv
// Randomised and directed checks of goertzel_bin against a plain-arithmetic Goertzel model.
module tb_goertzel_bin;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en_i = 1'b0;
    logic               mode_i = 1'b0;
    logic               clr_i = 1'b0;
    logic signed [17:0] coef_i = '0;
    logic               coef_valid_i = 1'b0;
    logic [31:0]        num_samp_i = '0;
    logic signed [15:0] samp_i = '0;
    logic               samp_valid_i = 1'b0;
    logic               busy_o;
    logic [31:0]        power_o;
    logic               valid_o;
    logic               ovf_o;

    int total = 0;
    int bad = 0;
    int tone[4] = '{1000, 0, -1000, 0};

    goertzel_bin dut (
        .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .clr_i(clr_i),
        .coef_i(coef_i), .coef_valid_i(coef_valid_i), .num_samp_i(num_samp_i),
        .samp_i(samp_i), .samp_valid_i(samp_valid_i), .busy_o(busy_o),
        .power_o(power_o), .valid_o(valid_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    // Goertzel recurrence and power formula evaluated with 64-bit integers.
    function automatic logic [31:0] ref_power(input longint c, input int n, input int xs[16]);
        longint s1 = 0, s2 = 0, sn, fb, r;
        for (int k = 0; k < n; k++) begin
            fb = (c * s1) >>> 16;
            sn = longint'(xs[k]) + fb - s2;
            s2 = s1;
            s1 = longint'(int'(sn));
        end
        fb = (c * s1) >>> 16;
        r = s1 * s1 + s2 * s2 - fb * s2;
        if (r < 0) return 32'd0;
        if (r > 64'sh0_FFFF_FFFF) return 32'hFFFF_FFFF;
        return r[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic start_block(input logic [17:0] c, input int n, input logic m);
        coef_i = c;
        num_samp_i = n;
        mode_i = m;
        en_i = 1'b1;
        coef_valid_i = 1'b1;
        samp_valid_i = 1'b0;
        tick();
    endtask

    task automatic feed(input int x, input int gap);
        repeat (gap) begin
            samp_valid_i = 1'b0;
            tick();
        end
        samp_valid_i = 1'b1;
        samp_i = x[15:0];
        tick();
        samp_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_o && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #3;
        total += 3;
        if (power_o !== 32'd0) begin bad++; $display("FAIL reset_power got=%h want=0", power_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        rst = 1'b0;
        en_i = 1'b1; coef_valid_i = 1'b1; num_samp_i = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (busy_o !== 1'b0) begin bad++; $display("FAIL n0_idle cycle=%0d busy=%b want=0", i, busy_o); end
        end
        start_block(18'd0, 4, 1'b0);
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy_o); end
        en_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b want=0", busy_o); end
        rst = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_tone();
        int lat;
        do_clr();
        start_block(18'd0, 4, 1'b0);
        for (int k = 0; k < 4; k++) feed(tone[k], 0);
        total += 2;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL tone_busy_fin got=%b want=1", busy_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL tone_valid_early got=%b want=0", valid_o); end
        wait_valid(lat);
        total += 3;
        if (lat !== 3) begin bad++; $display("FAIL tone_latency got=%0d want=3", lat); end
        if (power_o !== 32'd4_000_000) begin bad++; $display("FAIL tone_power got=%0d want=4000000", power_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL tone_busy_end got=%b want=0", busy_o); end
        $display("tone: power=%0d latency=%0d", power_o, lat);
    endtask

    task automatic test_dc_block_clr();
        int lat;
        do_clr();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL dc_clr_valid got=%b want=0", valid_o); end
        start_block(18'd0, 4, 1'b0);
        for (int k = 0; k < 4; k++) feed(1, 0);
        wait_valid(lat);
        total += 2;
        if (valid_o !== 1'b1) begin bad++; $display("FAIL dc_valid got=%b want=1", valid_o); end
        if (power_o !== 32'd0) begin bad++; $display("FAIL dc_power got=%0d want=0", power_o); end
        repeat (4) tick();
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL oneshot_block busy=%b want=0", busy_o); end
        do_clr();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL dc_clr2_valid got=%b want=0", valid_o); end
        tick();
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", busy_o); end
        for (int k = 0; k < 4; k++) feed(tone[k], 0);
        wait_valid(lat);
        total++;
        if (power_o !== 32'd4_000_000) begin bad++; $display("FAIL restart_power got=%0d want=4000000", power_o); end
        $display("dc: blocked then restarted, power=%0d", power_o);
    endtask

    task automatic test_continuous();
        do_clr();
        start_block(18'd0, 4, 1'b1);
        mode_i = 1'b0;
        for (int blk = 0; blk < 3; blk++) begin
            if (blk > 0) begin
                total++;
                if (valid_o !== 1'b1) begin bad++; $display("FAIL cont_valid_hold blk=%0d got=%b want=1", blk, valid_o); end
            end
            for (int k = 0; k < 4; k++) feed(tone[k], 1);
            if (blk == 2) en_i = 1'b0;
            samp_valid_i = 1'b1;
            samp_i = 16'sd12345;
            repeat (3) tick();
            samp_valid_i = 1'b0;
            total += 3;
            if (valid_o !== 1'b1) begin bad++; $display("FAIL cont_valid blk=%0d got=%b want=1", blk, valid_o); end
            if (power_o !== 32'd4_000_000) begin bad++; $display("FAIL cont_power blk=%0d got=%0d want=4000000", blk, power_o); end
            if (busy_o !== (blk < 2)) begin bad++; $display("FAIL cont_busy blk=%0d got=%b want=%b", blk, busy_o, blk < 2); end
            $display("continuous: block=%0d power=%0d busy=%b", blk, power_o, busy_o);
        end
    endtask

    task automatic test_clr_mid();
        int lat;
        do_clr();
        start_block(18'd0, 4, 1'b0);
        feed(1000, 0);
        feed(0, 0);
        do_clr();
        total += 2;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL clr_mid_busy got=%b want=0", busy_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL clr_mid_valid got=%b want=0", valid_o); end
        tick();
        for (int k = 0; k < 4; k++) feed(tone[k], 0);
        wait_valid(lat);
        total++;
        if (power_o !== 32'd4_000_000) begin bad++; $display("FAIL clr_mid_power got=%0d want=4000000", power_o); end
        $display("clr_mid: power after clear=%0d", power_o);
    endtask

    task automatic test_random();
        int xs[16];
        int n, lat;
        logic [17:0] cb;
        logic [31:0] exp_p;
        for (int t = 0; t < 24; t++) begin
            do_clr();
            cb = 18'($urandom);
            n = $urandom_range(1, 12);
            for (int k = 0; k < 16; k++) xs[k] = int'($urandom_range(4000)) - 2000;
            exp_p = ref_power(longint'($signed(cb)), n, xs);
            start_block(cb, n, 1'b0);
            en_i = 1'b0;
            coef_i = 18'($urandom);
            num_samp_i = $urandom_range(1, 12);
            mode_i = 1'($urandom);
            for (int k = 0; k < n; k++) feed(xs[k], $urandom_range(0, 2));
            wait_valid(lat);
            total += 3;
            if (lat !== 3) begin bad++; $display("FAIL rand_latency t=%0d got=%0d want=3", t, lat); end
            if (power_o !== exp_p) begin bad++; $display("FAIL rand_power t=%0d got=%h want=%h", t, power_o, exp_p); end
            if (busy_o !== 1'b0) begin bad++; $display("FAIL rand_busy t=%0d got=%b want=0", t, busy_o); end
            $display("random: t=%0d coef=%h n=%0d power=%h expected=%h", t, cb, n, power_o, exp_p);
            mode_i = 1'b0;
        end
    endtask

    task automatic test_ovf_off();
        total++;
        if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_tied got=%b want=0", ovf_o); end
        $display("ovf: flag=%b", ovf_o);
    endtask

    initial begin
        test_reset();
        test_tone();
        test_dc_block_clr();
        test_continuous();
        test_clr_mid();
        test_random();
        test_ovf_off();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
